// File: rtl/udp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : udp_pkg
//  Description : Shared constants, drop codes, receive FSM state encoding and
//                small helper functions for the UDP receive path.
//  Revision    : 1.0 - initial release
// ============================================================================
package udp_pkg;

    // Protocol constants
    localparam logic [3:0]  IP_VERSION    = 4'd4;
    localparam logic [3:0]  IHL_MIN       = 4'd5;
    localparam logic [7:0]  PROTO_UDP     = 8'd17;
    localparam logic [15:0] UDP_HDR_BYTES = 16'd8;
    localparam logic [16:0] IP_HDR_BYTES  = 17'd20;
    localparam logic [2:0]  IP_HDR_WORDS  = 3'd5;

    // Index of the last header word (udp_len/udp_csum)
    localparam logic [2:0]  HDR_LAST_WORD = 3'd6;

    // Drop reason codes; a lower value wins when several checks fail
    localparam logic [2:0]  DROP_NONE     = 3'd0;
    localparam logic [2:0]  DROP_VER      = 3'd1;
    localparam logic [2:0]  DROP_PROTO    = 3'd2;
    localparam logic [2:0]  DROP_DST_IP   = 3'd3;
    localparam logic [2:0]  DROP_CSUM     = 3'd4;
    localparam logic [2:0]  DROP_PORT     = 3'd5;
    localparam logic [2:0]  DROP_SHORT    = 3'd6;
    localparam logic [2:0]  DROP_ULEN     = 3'd7;

    // Receive FSM states
    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DRAIN   = 2'd2
    } rx_state_e;

    // Byte enables for the final payload word given the remaining byte count
    function automatic logic [3:0] keep_for_rem(input logic [15:0] rem);
        logic [3:0] keep;
        case (rem)
            16'd1:   keep = 4'b1000;
            16'd2:   keep = 4'b1100;
            16'd3:   keep = 4'b1110;
            default: keep = 4'b1111;
        endcase
        return keep;
    endfunction

    // Lowest non-zero drop code of the two (zero means "no reason")
    function automatic logic [2:0] min_code(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] r;
        if (a == DROP_NONE) begin
            r = b;
        end else if (b == DROP_NONE) begin
            r = a;
        end else if (b < a) begin
            r = b;
        end else begin
            r = a;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/udp_packet_rx_csum.sv
`default_nettype none
// ============================================================================
//  Module      : ip_hdr_csum_check
//  Description : Ones-complement IPv4 header checksum checker. Accumulates
//                both 16-bit halves of each valid header word into a 20-bit
//                sum and folds the carries twice; pass when the folded value
//                is all ones.
//  Revision    : 1.0 - initial release
// ============================================================================
module ip_hdr_csum_check (
    input  logic        clk_32,
    input  logic        reset_32,
    input  logic [31:0] word_i,
    input  logic        word_valid_i,
    input  logic        clear_i,
    output logic        pass_o
);

    logic [19:0] acc_q;
    logic [19:0] acc_d;
    logic [16:0] half_sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    // Next accumulator: clear restarts the sum, optionally seeding it with
    // the word presented in the same cycle (the first header word)
    always_comb begin
        half_sum = {1'b0, word_i[31:16]} + {1'b0, word_i[15:0]};
        acc_d    = acc_q;
        if (clear_i) begin
            acc_d = word_valid_i ? {3'b000, half_sum} : 20'd0;
        end else if (word_valid_i) begin
            acc_d = acc_q + {3'b000, half_sum};
        end
    end

    // Accumulator register
    always_ff @(posedge clk_32 or posedge reset_32) begin
        if (reset_32) begin
            acc_q <= 20'd0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // Two carry folds bring ten halves (max 20 bits) back to 16 bits
    always_comb begin
        fold1  = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
        fold2  = fold1[15:0] + {15'd0, fold1[16]};
        pass_o = (fold2 == 16'hFFFF);
    end

endmodule
`default_nettype wire

// File: rtl/udp_packet_rx.sv
`default_nettype none
// ============================================================================
//  Module      : udp_packet_rx
//  Description : IPv4/UDP receive path. Parses and filters the 7-word IP+UDP
//                header from a 32-bit stream, delivers the UDP payload with
//                keep/last, reports per-packet metadata and drop reasons.
//  Revision    : 1.0 - initial release
// ============================================================================
module udp_packet_rx
    import udp_pkg::*;
#(
    parameter int CHECK_CSUM = 1,
    parameter int DEBUG      = 0
) (
    input  logic        clk_32,
    input  logic        reset_32,
    input  logic [31:0] local_IP_in,
    input  logic [15:0] local_port_in,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [31:0] m_tdata,
    output logic [3:0]  m_tkeep,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic        rx_meta_valid,
    output logic [31:0] rx_src_ip,
    output logic [15:0] rx_src_port,
    output logic [15:0] rx_length,
    output logic        rx_drop,
    output logic [2:0]  rx_drop_code,
    output logic        rx_trunc
);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    rx_state_e   state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  reason_q;
    logic [15:0] total_len_q;
    logic [31:0] src_ip_q;
    logic [15:0] src_port_q;
    logic [15:0] rem_q;

    logic [31:0] m_tdata_q;
    logic [3:0]  m_tkeep_q;
    logic        m_tvalid_q;
    logic        m_tlast_q;

    logic        rx_meta_valid_q;
    logic [31:0] rx_src_ip_q;
    logic [15:0] rx_src_port_q;
    logic [15:0] rx_length_q;
    logic        rx_drop_q;
    logic [2:0]  rx_drop_code_q;
    logic        rx_trunc_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        s_xfer;
    logic        csum_pass;
    logic        csum_fail;
    logic        csum_valid;
    logic        csum_clear;
    logic [15:0] udp_len;
    logic [16:0] udp_len_max;
    logic        udp_len_bad;
    logic [2:0]  word_code;
    logic [2:0]  reason_d;
    logic        hdr_done;
    logic        pay_last;
    logic [3:0]  pay_keep;
    logic [15:0] rem_d;

    // Input accept: header and drain states always accept; in payload the
    // single output register can take a word when empty or being emptied
    always_comb begin
        s_tready = 1'b1;
        if (state_q == ST_PAYLOAD) begin
            s_tready = m_tready | ~m_tvalid_q;
        end
    end

    assign s_xfer = s_tvalid & s_tready;

    // Checksum accumulates header words 0..4; word 0 restarts the sum
    assign csum_valid = (state_q == ST_HDR) && s_xfer && (cnt_q < IP_HDR_WORDS);
    assign csum_clear = (state_q == ST_HDR) && s_xfer && (cnt_q == 3'd0);

    ip_hdr_csum_check u_csum (
        .clk_32       (clk_32),
        .reset_32     (reset_32),
        .word_i       (s_tdata),
        .word_valid_i (csum_valid),
        .clear_i      (csum_clear),
        .pass_o       (csum_pass)
    );

    // Per-word header checks; the lowest failing code across the header wins
    always_comb begin
        csum_fail   = (CHECK_CSUM != 0) && !csum_pass;
        udp_len     = s_tdata[31:16];
        // 17-bit difference so total_len < 20 shows up as a set bit 16
        udp_len_max = {1'b0, total_len_q} - IP_HDR_BYTES;
        udp_len_bad = (udp_len < UDP_HDR_BYTES) || udp_len_max[16] ||
                      ({1'b0, udp_len} > udp_len_max);
        word_code   = DROP_NONE;
        case (cnt_q)
            3'd0: begin
                if ((s_tdata[31:28] != IP_VERSION) || (s_tdata[27:24] != IHL_MIN)) begin
                    word_code = DROP_VER;
                end
            end
            3'd1: begin
                // MF flag or non-zero fragment offset means a fragment
                if (s_tdata[13] || (s_tdata[12:0] != 13'd0)) begin
                    word_code = DROP_PROTO;
                end
            end
            3'd2: begin
                if (s_tdata[23:16] != PROTO_UDP) begin
                    word_code = DROP_PROTO;
                end
            end
            3'd4: begin
                if (s_tdata != local_IP_in) begin
                    word_code = DROP_DST_IP;
                end
            end
            3'd5: begin
                // Accumulator now holds words 0..4, so the sum is final here
                if (csum_fail) begin
                    word_code = DROP_CSUM;
                end else if (s_tdata[15:0] != local_port_in) begin
                    word_code = DROP_PORT;
                end
            end
            3'd6: begin
                if (udp_len_bad) begin
                    word_code = DROP_ULEN;
                end
            end
            default: begin
                word_code = DROP_NONE;
            end
        endcase
        word_code = min_code(word_code, s_tlast ? DROP_SHORT : DROP_NONE);
        reason_d  = min_code(reason_q, word_code);
        hdr_done  = s_tlast || (cnt_q == HDR_LAST_WORD);
    end

    // Payload word framing from the remaining byte count
    always_comb begin
        pay_last = (rem_q <= 16'd4);
        pay_keep = keep_for_rem(rem_q);
        rem_d    = pay_last ? 16'd0 : (rem_q - 16'd4);
    end

    // Receive FSM with registered stream and sideband outputs
    always_ff @(posedge clk_32 or posedge reset_32) begin
        if (reset_32) begin
            state_q         <= ST_HDR;
            cnt_q           <= 3'd0;
            reason_q        <= DROP_NONE;
            total_len_q     <= 16'd0;
            src_ip_q        <= 32'd0;
            src_port_q      <= 16'd0;
            rem_q           <= 16'd0;
            m_tdata_q       <= 32'd0;
            m_tkeep_q       <= 4'd0;
            m_tvalid_q      <= 1'b0;
            m_tlast_q       <= 1'b0;
            rx_meta_valid_q <= 1'b0;
            rx_src_ip_q     <= 32'd0;
            rx_src_port_q   <= 16'd0;
            rx_length_q     <= 16'd0;
            rx_drop_q       <= 1'b0;
            rx_drop_code_q  <= DROP_NONE;
            rx_trunc_q      <= 1'b0;
        end else begin
            rx_meta_valid_q <= 1'b0;
            rx_drop_q       <= 1'b0;
            rx_trunc_q      <= 1'b0;

            // A pending output word leaves once accepted, in any state;
            // a payload load below overrides this in the same cycle
            if (m_tready) begin
                m_tvalid_q <= 1'b0;
            end

            case (state_q)
                ST_HDR: begin
                    if (s_xfer) begin
                        if (cnt_q == 3'd0) begin
                            total_len_q <= s_tdata[15:0];
                        end
                        if (cnt_q == 3'd3) begin
                            src_ip_q <= s_tdata;
                        end
                        if (cnt_q == 3'd5) begin
                            src_port_q <= s_tdata[31:16];
                        end

                        if (hdr_done) begin
                            cnt_q    <= 3'd0;
                            reason_q <= DROP_NONE;
                            if (reason_d != DROP_NONE) begin
                                rx_drop_q      <= 1'b1;
                                rx_drop_code_q <= reason_d;
                                state_q        <= s_tlast ? ST_HDR : ST_DRAIN;
                            end else begin
                                rx_meta_valid_q <= 1'b1;
                                rx_src_ip_q     <= src_ip_q;
                                rx_src_port_q   <= src_port_q;
                                rx_length_q     <= udp_len - UDP_HDR_BYTES;
                                rem_q           <= udp_len - UDP_HDR_BYTES;
                                if (udp_len == UDP_HDR_BYTES) begin
                                    state_q <= s_tlast ? ST_HDR : ST_DRAIN;
                                end else begin
                                    state_q <= ST_PAYLOAD;
                                end
                            end
                        end else begin
                            cnt_q    <= cnt_q + 3'd1;
                            reason_q <= reason_d;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (s_xfer) begin
                        m_tdata_q  <= s_tdata;
                        m_tvalid_q <= 1'b1;
                        rem_q      <= rem_d;
                        if (pay_last) begin
                            m_tkeep_q <= pay_keep;
                            m_tlast_q <= 1'b1;
                            // Anything after the payload is Ethernet padding
                            state_q   <= s_tlast ? ST_HDR : ST_DRAIN;
                        end else if (s_tlast) begin
                            // Stream ended early: close the payload here
                            m_tkeep_q  <= 4'b1111;
                            m_tlast_q  <= 1'b1;
                            rx_trunc_q <= 1'b1;
                            state_q    <= ST_HDR;
                        end else begin
                            m_tkeep_q <= 4'b1111;
                            m_tlast_q <= 1'b0;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (s_xfer && s_tlast) begin
                        cnt_q   <= 3'd0;
                        state_q <= ST_HDR;
                    end
                end

                default: begin
                    cnt_q   <= 3'd0;
                    state_q <= ST_HDR;
                end
            endcase
        end
    end

    // Debug hook: no functional logic; probes may be attached here
    if (DEBUG != 0) begin : g_debug
    end

    assign m_tdata       = m_tdata_q;
    assign m_tkeep       = m_tkeep_q;
    assign m_tvalid      = m_tvalid_q;
    assign m_tlast       = m_tlast_q;
    assign rx_meta_valid = rx_meta_valid_q;
    assign rx_src_ip     = rx_src_ip_q;
    assign rx_src_port   = rx_src_port_q;
    assign rx_length     = rx_length_q;
    assign rx_drop       = rx_drop_q;
    assign rx_drop_code  = rx_drop_code_q;
    assign rx_trunc      = rx_trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_udp_packet_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_udp_packet_rx
//  Description : Directed self-checking bench for udp_packet_rx. A second
//                instance with the checksum check disabled shares the input
//                stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_packet_rx;

    localparam logic [31:0] LOCAL_IP   = 32'hC0A8010A;  // 192.168.1.10
    localparam logic [31:0] OTHER_IP   = 32'hC0A8010B;  // 192.168.1.11
    localparam logic [15:0] LOCAL_PORT = 16'd5000;
    localparam logic [31:0] SRC_IP     = 32'h0A000001;
    localparam logic [15:0] SRC_PORT   = 16'd1234;

    logic        clk_32   = 1'b0;
    logic        reset_32 = 1'b1;
    logic [31:0] local_IP_in   = LOCAL_IP;
    logic [15:0] local_port_in = LOCAL_PORT;
    logic [31:0] s_tdata  = 32'd0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast  = 1'b0;
    logic        m_tready = 1'b1;

    logic        s_tready, m_tvalid, m_tlast, rx_meta_valid, rx_drop, rx_trunc;
    logic [31:0] m_tdata, rx_src_ip;
    logic [3:0]  m_tkeep;
    logic [15:0] rx_src_port, rx_length;
    logic [2:0]  rx_drop_code;

    logic        n_s_tready, n_m_tvalid, n_m_tlast, n_meta_valid, n_drop, n_trunc;
    logic [31:0] n_m_tdata, n_src_ip;
    logic [3:0]  n_m_tkeep;
    logic [15:0] n_src_port, n_length;
    logic [2:0]  n_drop_code;

    udp_packet_rx #(.CHECK_CSUM(1), .DEBUG(0)) dut (
        .clk_32(clk_32), .reset_32(reset_32),
        .local_IP_in(local_IP_in), .local_port_in(local_port_in),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready),
        .rx_meta_valid(rx_meta_valid), .rx_src_ip(rx_src_ip), .rx_src_port(rx_src_port),
        .rx_length(rx_length), .rx_drop(rx_drop), .rx_drop_code(rx_drop_code),
        .rx_trunc(rx_trunc)
    );

    udp_packet_rx #(.CHECK_CSUM(0), .DEBUG(0)) dut_nocsum (
        .clk_32(clk_32), .reset_32(reset_32),
        .local_IP_in(local_IP_in), .local_port_in(local_port_in),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(n_s_tready),
        .m_tdata(n_m_tdata), .m_tkeep(n_m_tkeep), .m_tvalid(n_m_tvalid), .m_tlast(n_m_tlast),
        .m_tready(m_tready),
        .rx_meta_valid(n_meta_valid), .rx_src_ip(n_src_ip), .rx_src_port(n_src_port),
        .rx_length(n_length), .rx_drop(n_drop), .rx_drop_code(n_drop_code),
        .rx_trunc(n_trunc)
    );

    always #5 clk_32 = ~clk_32;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observation state filled by the monitor
    logic [31:0] got_d[$];
    logic [3:0]  got_k[$];
    logic        got_l[$];
    int          meta_cnt, drop_cnt, trunc_cnt, n_meta_cnt, n_drop_cnt, n_words;
    logic [2:0]  drop_code_seen;
    logic        prev_v = 1'b0, prev_r = 1'b1;
    logic [36:0] prev_bus = '0;
    bit          rdy_toggle = 1'b0;

    logic [31:0] pkt[$];
    logic [31:0] exp_pay[$];

    always @(negedge clk_32) begin
        if (!reset_32) begin
            if (prev_v && !prev_r) begin
                check_eq("stall_valid", m_tvalid, 1);
                check_eq("stall_bus", {m_tlast, m_tkeep, m_tdata}, prev_bus);
            end
            if (m_tvalid && m_tready) begin
                got_d.push_back(m_tdata);
                got_k.push_back(m_tkeep);
                got_l.push_back(m_tlast);
            end
            if (rx_meta_valid) meta_cnt++;
            if (rx_drop) begin
                drop_cnt++;
                drop_code_seen = rx_drop_code;
            end
            if (rx_trunc) trunc_cnt++;
            if (n_meta_valid) n_meta_cnt++;
            if (n_drop) n_drop_cnt++;
            if (n_m_tvalid && m_tready) n_words++;
        end
        prev_v   = m_tvalid;
        prev_r   = m_tready;
        prev_bus = {m_tlast, m_tkeep, m_tdata};
    end

    // Downstream ready: steady 1, or 1010... when toggling is enabled
    initial begin
        forever begin
            @(posedge clk_32);
            #1;
            if (rdy_toggle) m_tready = ~m_tready;
            else            m_tready = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] ip_csum(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d,
                                            input logic [31:0] e);
        logic [31:0] s;
        s = 32'(a[31:16]) + 32'(a[15:0]) + 32'(b[31:16]) + 32'(b[15:0]) +
            32'(c[31:16]) + 32'(c[15:0]) + 32'(d[31:16]) + 32'(d[15:0]) +
            32'(e[31:16]) + 32'(e[15:0]);
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        return ~s[15:0];
    endfunction

    task automatic build_pkt(input logic [31:0] dst, input logic [7:0] proto,
                             input logic [15:0] dport, input logic [15:0] ulen,
                             input int n_pay, input int n_pad, input int seed, input bit flip);
        logic [31:0] w0, w1, w2, w3, w4, p;
        logic [15:0] tot;
        tot = ulen + 16'd20;
        w0  = {4'h4, 4'h5, 8'h00, tot};
        w1  = {16'h1C46, 16'h4000};
        w2  = {8'h40, proto, 16'h0000};
        w3  = SRC_IP;
        w4  = dst;
        w2[15:0] = ip_csum(w0, w1, w2, w3, w4);
        if (flip) w3[8] = ~w3[8];
        pkt.delete();
        exp_pay.delete();
        pkt.push_back(w0); pkt.push_back(w1); pkt.push_back(w2);
        pkt.push_back(w3); pkt.push_back(w4);
        pkt.push_back({SRC_PORT, dport});
        pkt.push_back({ulen, 16'h0000});
        for (int i = 0; i < n_pay; i++) begin
            p = {4'hD, 4'(seed), 8'(i), 8'hA5, 8'(255 - i)};
            pkt.push_back(p);
            exp_pay.push_back(p);
        end
        for (int i = 0; i < n_pad; i++) pkt.push_back(32'h0000_0000);
    endtask

    task automatic send_words(input int last_idx, input bit tlast_en);
        for (int i = 0; i <= last_idx; i++) begin
            int   waits;
            logic acc;
            waits    = 0;
            s_tdata  = pkt[i];
            s_tvalid = 1'b1;
            s_tlast  = tlast_en && (i == last_idx);
            do begin
                @(negedge clk_32);
                acc = s_tready;
                @(posedge clk_32);
                #1;
                waits++;
            end while (!acc && waits < 100);
            if (!acc) check_eq("tready_timeout", 0, 1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic settle();
        rdy_toggle = 1'b0;
        s_tvalid   = 1'b0;
        repeat (10) @(posedge clk_32);
        #1;
    endtask

    task automatic clear_obs();
        got_d.delete(); got_k.delete(); got_l.delete();
        meta_cnt = 0; drop_cnt = 0; trunc_cnt = 0;
        n_meta_cnt = 0; n_drop_cnt = 0; n_words = 0;
        drop_code_seen = 3'd0;
    endtask

    task automatic expect_out(input string tag, input int n_w, input logic [3:0] last_keep,
                              input int n_meta, input int n_drop, input logic [2:0] code,
                              input int n_trunc);
        check_eq({tag, "_nwords"}, got_d.size(), n_w);
        for (int i = 0; i < n_w && i < got_d.size(); i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), got_d[i], exp_pay[i]);
            check_eq($sformatf("%s_keep%0d", tag, i), got_k[i], (i == n_w - 1) ? last_keep : 4'hF);
            check_eq($sformatf("%s_last%0d", tag, i), got_l[i], (i == n_w - 1) ? 1 : 0);
        end
        check_eq({tag, "_meta"}, meta_cnt, n_meta);
        check_eq({tag, "_drop"}, drop_cnt, n_drop);
        if (n_drop > 0) check_eq({tag, "_code"}, drop_code_seen, code);
        check_eq({tag, "_trunc"}, trunc_cnt, n_trunc);
    endtask

    initial begin
        clear_obs();
        // Reset state
        repeat (3) @(posedge clk_32);
        #1;
        check_eq("rst_s_tready", s_tready, 1);
        check_eq("rst_m_tvalid", m_tvalid, 0);
        check_eq("rst_m_tkeep", m_tkeep, 0);
        check_eq("rst_meta", rx_meta_valid, 0);
        check_eq("rst_drop_code", rx_drop_code, 0);
        check_eq("rst_length", rx_length, 0);
        reset_32 = 1'b0;
        repeat (2) @(posedge clk_32);
        #1;

        // T1: clean 64-byte payload
        clear_obs();
        build_pkt(LOCAL_IP, 8'd17, LOCAL_PORT, 16'd72, 16, 0, 1, 0);
        send_words(pkt.size() - 1, 1);
        settle();
        expect_out("t1", 16, 4'hF, 1, 0, 3'd0, 0);
        check_eq("t1_len", rx_length, 16'd64);
        check_eq("t1_src_ip", rx_src_ip, SRC_IP);
        check_eq("t1_src_port", rx_src_port, SRC_PORT);
        check_eq("t1_nocsum_meta", n_meta_cnt, 1);

        // T2: 7-byte payload plus two padding words
        clear_obs();
        build_pkt(LOCAL_IP, 8'd17, LOCAL_PORT, 16'd15, 2, 2, 2, 0);
        send_words(pkt.size() - 1, 1);
        settle();
        expect_out("t2", 2, 4'b1110, 1, 0, 3'd0, 0);
        check_eq("t2_len", rx_length, 16'd7);

        // T3: wrong destination IP
        clear_obs();
        build_pkt(OTHER_IP, 8'd17, LOCAL_PORT, 16'd16, 2, 0, 3, 0);
        send_words(pkt.size() - 1, 1);
        settle();
        expect_out("t3", 0, 4'hF, 0, 1, 3'd3, 0);

        // T4: bad checksum; the unchecked instance accepts it
        clear_obs();
        build_pkt(LOCAL_IP, 8'd17, LOCAL_PORT, 16'd16, 2, 0, 4, 1);
        send_words(pkt.size() - 1, 1);
        settle();
        expect_out("t4", 0, 4'hF, 0, 1, 3'd4, 0);
        check_eq("t4_nocsum_meta", n_meta_cnt, 1);
        check_eq("t4_nocsum_drop", n_drop_cnt, 0);
        check_eq("t4_nocsum_words", n_words, 2);

        // T5: TCP protocol and wrong port together
        clear_obs();
        build_pkt(LOCAL_IP, 8'd6, 16'd5001, 16'd16, 2, 0, 5, 0);
        send_words(pkt.size() - 1, 1);
        settle();
        expect_out("t5", 0, 4'hF, 0, 1, 3'd2, 0);

        // T6: 64-byte payload with m_tready toggling
        clear_obs();
        build_pkt(LOCAL_IP, 8'd17, LOCAL_PORT, 16'd72, 16, 0, 6, 0);
        rdy_toggle = 1'b1;
        send_words(pkt.size() - 1, 1);
        settle();
        expect_out("t6", 16, 4'hF, 1, 0, 3'd0, 0);

        // T7: s_tlast on header word 3, then a clean packet
        clear_obs();
        build_pkt(LOCAL_IP, 8'd17, LOCAL_PORT, 16'd72, 16, 0, 7, 0);
        send_words(3, 1);
        settle();
        expect_out("t7", 0, 4'hF, 0, 1, 3'd6, 0);
        clear_obs();
        build_pkt(LOCAL_IP, 8'd17, LOCAL_PORT, 16'd16, 2, 0, 8, 0);
        send_words(pkt.size() - 1, 1);
        settle();
        expect_out("t7b", 2, 4'hF, 1, 0, 3'd0, 0);

        // T8: s_tlast on the 5th payload word of a 64-byte packet
        clear_obs();
        build_pkt(LOCAL_IP, 8'd17, LOCAL_PORT, 16'd72, 16, 0, 9, 0);
        send_words(11, 1);
        settle();
        expect_out("t8", 5, 4'hF, 1, 0, 3'd0, 1);

        // T9: reset in the middle of a payload, then a clean packet
        clear_obs();
        build_pkt(LOCAL_IP, 8'd17, LOCAL_PORT, 16'd72, 16, 0, 10, 0);
        send_words(10, 0);
        check_eq("t9_pre_valid", m_tvalid, 1);
        #2;
        reset_32 = 1'b1;
        #1;
        check_eq("t9_rst_valid", m_tvalid, 0);
        check_eq("t9_rst_ready", s_tready, 1);
        @(posedge clk_32);
        #1;
        reset_32 = 1'b0;
        clear_obs();
        build_pkt(LOCAL_IP, 8'd17, LOCAL_PORT, 16'd16, 2, 0, 11, 0);
        send_words(pkt.size() - 1, 1);
        settle();
        expect_out("t9", 2, 4'hF, 1, 0, 3'd0, 0);
        check_eq("t9_len", rx_length, 16'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
